result_serializer: RTL and testbench
====================================

// Module: result_serializer
// PURPOSE
//  Reads the 32 channel results after the polynomial control unit asserts its one-cycle srdyo pulse.
//  Captures all 32 words in one cycle into a shadow buffer, freeing the upstream output registers for the next frame.
//  Streams the words out one per accepted cycle on a valid/ready port, channel 0 first, tagged with channel index.
//  Sits between the polynomial datapath's 32 result registers and the downstream host/packer.
// PARAMETERS
//  DATA_W   32  width of one channel result word
//  N_CH     32  channels per frame (channel index width CH_W = 5)
// PORTS
//  clk            in   1           rising-edge clock
//  GlobalReset_n  in   1           asynchronous, active-low reset
//  frame_rdy      in   1           one-cycle pulse: results_flat valid this cycle (upstream srdyo)
//  results_flat   in   N_CH*DATA_W ch k at [k*DATA_W +: DATA_W]
//  dout           out  DATA_W      current result word
//  dout_ch        out  5           channel index of dout
//  dout_valid     out  1           dout/dout_ch/dout_last valid
//  dout_last      out  1           high with dout_ch==N_CH-1
//  dout_ready     in   1           downstream accepts when valid&ready
//  busy           out  1           frame held, not fully drained
//  frame_done     out  1           one-cycle pulse after last word accepted
//  overrun        out  1           sticky: frame_rdy dropped while busy
//  clr_overrun    in   1           synchronous clear of overrun
//  frame_cnt      out  16          frames fully drained, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (async, GlobalReset_n=0): state IDLE; every output 0; buffer contents don't-care. Reset mid-stream aborts the frame with no frame_done.
//  States: IDLE, STREAM.
//  IDLE: frame_rdy=1 -> capture all N_CH words, rd_ptr<=0, go STREAM. Next cycle dout_valid=1, dout_ch=0, busy=1 (latency 1).
//  STREAM, valid&ready: rd_ptr++ and next word appears the following cycle. Throughput 1 word/clk; 32 clk/frame at ready=1.
//  STREAM, valid&!ready: dout, dout_ch, dout_last, dout_valid held stable.
//  Last-word handshake (dout_ch=31 & ready): frame_done=1 and frame_cnt++ the next cycle.
//  -> If frame_rdy is not in the same cycle: go IDLE; dout_valid=0 and busy=0 the next cycle.
//  -> If frame_rdy is in the same cycle: capture the new frame, stay STREAM, dout_ch=0 next cycle. No bubble, no overrun.
//  frame_rdy in STREAM, any cycle other than the last-word handshake: new frame dropped, buffer untouched, overrun<=1.
//  Overrun clear: clr_overrun=1 clears overrun. If clr_overrun and a drop occur in the same cycle, set wins (overrun=1).
//  frame_rdy while GlobalReset_n=0: ignored.
//  Timing margin: the upstream frame period exceeds 400 clk, so overrun only occurs when dout_ready stalls for >~370 cycles in total.
//  Datapath: dout is a direct word-select of the buffer by rd_ptr. rd_ptr is 5 bits; no wrap beyond 31 (state exits).
//  Arithmetic: unsigned throughout. frame_cnt wraps modulo 2^16.
// STRUCTURE
//  Shared package: N_CH, CH_W=5, state encoding (IDLE=1'b0, STREAM=1'b1), frame_cnt width 16.
//  One sub-module: result_buffer (N_CH x DATA_W register file).
//  -> Parallel load enable.
//  -> Combinational read by 5-bit index.
//  FSM, rd_ptr, overrun and counters stay in the top module.
// TESTING
//  1. Reset, then frame_rdy with word k = 32'h1000_0000+k, ready=1 -> dout_ch 0..31 on 32 consecutive clk.
//     Values match; dout_last only at ch 31; frame_done 1 clk after; frame_cnt=1.
//  2. Same frame, ready toggles 1/0 every clk -> words held while ready=0, order intact, 64 clk drain, no overrun.
//  3. frame_rdy again at ch 10 (ready=1) -> frame dropped.
//     Original words continue unchanged; overrun=1 until clr_overrun; frame_cnt=1 at end.
//  4. frame_rdy in the same clk as the ch 31 handshake (new data 32'hA000_0000+k) -> next clk dout_ch=0, dout=32'hA000_0000.
//     busy stays 1; overrun=0.
//  5. GlobalReset_n low at ch 17 -> dout_valid, busy, overrun, frame_cnt=0 immediately (async); no frame_done; next frame_rdy starts at ch 0.
//  6. Drop and clr_overrun in the same clk -> overrun=1. Preload frame_cnt to 0xFFFF via 65535 frames (or force) -> the next frame gives 0.

Source files
------------

// File: rtl/result_serializer_pkg.sv
// Shared types and sizes for the result serializer.
// Frame geometry, FSM encoding and counter width.
package result_serializer_pkg;
  localparam int N_CH  = 32;
  localparam int CH_W  = 5;
  localparam int CNT_W = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;
endpackage

// File: rtl/result_buffer.sv
// Shadow register file for one frame of channel results.
// Whole-frame parallel load, combinational word read.
module result_buffer
  import result_serializer_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   load,
  input  logic [N_CH*DATA_W-1:0] din_flat,
  input  logic [CH_W-1:0]        idx,
  output logic [DATA_W-1:0]      rdata
);

  logic [DATA_W-1:0] mem [N_CH];

  // Contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < N_CH; k++) begin
        mem[k] <= din_flat[k*DATA_W +: DATA_W];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/result_serializer.sv
// Captures a full frame of channel results and streams it out
// one word per accepted cycle, channel 0 first.
module result_serializer
  import result_serializer_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   GlobalReset_n,
  input  logic                   frame_rdy,
  input  logic [N_CH*DATA_W-1:0] results_flat,
  output logic [DATA_W-1:0]      dout,
  output logic [CH_W-1:0]        dout_ch,
  output logic                   dout_valid,
  output logic                   dout_last,
  input  logic                   dout_ready,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overrun,
  input  logic                   clr_overrun,
  output logic [CNT_W-1:0]       frame_cnt
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [CH_W-1:0]   rd_ptr;
  logic [DATA_W-1:0] rdata;
  logic              hs;
  logic              last_hs;
  logic              load;
  logic              drop;

  assign hs      = (state == STREAM) & dout_ready;
  assign last_hs = hs & (rd_ptr == LAST_CH);
  // A new frame is only taken when nothing is held, or on the
  // exact cycle the held frame's last word leaves.
  assign load    = frame_rdy & ((state == IDLE) | last_hs);
  assign drop    = frame_rdy & (state == STREAM) & ~last_hs;

  result_buffer #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk      (clk),
    .load     (load),
    .din_flat (results_flat),
    .idx      (rd_ptr),
    .rdata    (rdata)
  );

  always_ff @(posedge clk or negedge GlobalReset_n) begin
    if (!GlobalReset_n) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (frame_rdy) state_nxt = STREAM;
      STREAM:  if (last_hs && !frame_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dout_valid = (state == STREAM);
    busy       = (state == STREAM);
    dout_last  = dout_valid && (rd_ptr == LAST_CH);
    dout       = dout_valid ? rdata : '0;
    dout_ch    = dout_valid ? rd_ptr : '0;
  end

  always_ff @(posedge clk or negedge GlobalReset_n) begin
    if (!GlobalReset_n) begin
      rd_ptr <= '0;
    end else if (load) begin
      rd_ptr <= '0;
    end else if (hs) begin
      rd_ptr <= last_hs ? '0 : rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge GlobalReset_n) begin
    if (!GlobalReset_n) begin
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= last_hs;
      if (last_hs) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge clk or negedge GlobalReset_n) begin
    if (!GlobalReset_n)   overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end

endmodule

// File: tb/tb_result_serializer.sv
// Scoreboard bench for result_serializer.
// Expected words queued at frame accept, popped on handshake.
module tb_result_serializer;
  import result_serializer_pkg::*;

  typedef struct packed {
    logic [4:0]  ch;
    logic [31:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              frame_rdy = 1'b0;
  logic [N_CH*32-1:0] results_flat = '0;
  logic [31:0]       dout;
  logic [4:0]        dout_ch;
  logic              dout_valid;
  logic              dout_last;
  logic              dout_ready = 1'b0;
  logic              busy;
  logic              frame_done;
  logic              overrun;
  logic              clr_overrun = 1'b0;
  logic [15:0]       frame_cnt;

  result_serializer #(.DATA_W(32)) dut (
    .clk           (clk),
    .GlobalReset_n (rst_n),
    .frame_rdy     (frame_rdy),
    .results_flat  (results_flat),
    .dout          (dout),
    .dout_ch       (dout_ch),
    .dout_valid    (dout_valid),
    .dout_last     (dout_last),
    .dout_ready    (dout_ready),
    .busy          (busy),
    .frame_done    (frame_done),
    .overrun       (overrun),
    .clr_overrun   (clr_overrun),
    .frame_cnt     (frame_cnt)
  );

  always #5 clk = ~clk;

  int          ntot = 0;
  int          npass = 0;
  exp_t        q[$];
  logic [31:0] cur [N_CH];
  logic        exp_done = 1'b0;
  logic [15:0] mcnt = '0;
  logic        movr = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] pd = '0;
  logic [4:0]  pc = '0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    ntot++;
    if (got !== exp)
      $display("FAIL %s got %h exp %h", tag, got, exp);
    else
      npass++;
  endtask

  task automatic mon();
    exp_t e;
    if (!rst_n) return;
    chk("valid", 64'(dout_valid), 64'(q.size() != 0));
    chk("busy", 64'(busy), 64'(q.size() != 0));
    chk("done", 64'(frame_done), 64'(exp_done));
    chk("cnt", 64'(frame_cnt), 64'(mcnt));
    chk("ovr", 64'(overrun), 64'(movr));
    if (stall) begin
      chk("hold_d", 64'(dout), 64'(pd));
      chk("hold_ch", 64'(dout_ch), 64'(pc));
    end
    exp_done = 1'b0;
    stall = 1'b0;
    if (q.size() != 0) begin
      e = q[0];
      chk("dout", 64'(dout), 64'(e.data));
      chk("ch", 64'(dout_ch), 64'(e.ch));
      chk("last", 64'(dout_last), 64'(e.ch == 5'd31));
      if (dout_ready) begin
        void'(q.pop_front());
        if (q.size() == 0) begin
          exp_done = 1'b1;
          mcnt = mcnt + 16'd1;
        end
      end else begin
        stall = 1'b1;
        pd = dout;
        pc = dout_ch;
      end
    end
    if (frame_rdy) begin
      if (q.size() == 0) begin
        for (int k = 0; k < N_CH; k++) begin
          e.ch = 5'(k);
          e.data = cur[k];
          q.push_back(e);
        end
      end else begin
        movr = 1'b1;
      end
    end else if (clr_overrun) begin
      movr = 1'b0;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(input logic [31:0] base);
    for (int k = 0; k < N_CH; k++) begin
      cur[k] = base + 32'(k);
      results_flat[k*32 +: 32] = base + 32'(k);
    end
  endtask

  task automatic send_frame(input logic [31:0] base);
    set_frame(base);
    frame_rdy = 1'b1;
    cyc();
    frame_rdy = 1'b0;
  endtask

  task automatic drain(input bit tog, input int want);
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      cyc();
      n++;
      if (tog) dout_ready = ~dout_ready;
    end
    if (n >= 300) chk("drain_timeout", 64'(n), 64'(0));
    if (want > 0) chk("drain_clk", 64'(n), 64'(want));
    cyc();
    cyc();
  endtask

  task automatic rst_chk();
    chk("rst_valid", 64'(dout_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_dout", 64'(dout), 64'(0));
    chk("rst_ch", 64'(dout_ch), 64'(0));
    chk("rst_last", 64'(dout_last), 64'(0));
    chk("rst_done", 64'(frame_done), 64'(0));
    chk("rst_ovr", 64'(overrun), 64'(0));
    chk("rst_cnt", 64'(frame_cnt), 64'(0));
  endtask

  initial begin
    #2;
    rst_chk();
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // 1: straight drain at full rate
    dout_ready = 1'b1;
    send_frame(32'h1000_0000);
    drain(1'b0, 32);

    // 2: ready toggling every clock
    dout_ready = 1'b0;
    send_frame(32'h1000_0000);
    drain(1'b1, 64);
    dout_ready = 1'b1;

    // 3: frame arrives mid-stream and is dropped
    send_frame(32'h1000_0000);
    repeat (10) cyc();
    set_frame(32'hB000_0000);
    frame_rdy = 1'b1;
    cyc();
    frame_rdy = 1'b0;
    drain(1'b0, 0);
    clr_overrun = 1'b1;
    cyc();
    clr_overrun = 1'b0;
    cyc();

    // 4: new frame on the last-word handshake
    send_frame(32'h1000_0000);
    repeat (31) cyc();
    set_frame(32'hA000_0000);
    frame_rdy = 1'b1;
    cyc();
    frame_rdy = 1'b0;
    drain(1'b0, 0);

    // 5: async reset in the middle of a frame
    send_frame(32'h2000_0000);
    repeat (5) cyc();
    set_frame(32'hC000_0000);
    frame_rdy = 1'b1;
    cyc();
    frame_rdy = 1'b0;
    repeat (11) cyc();
    chk("pre_rst_ch", 64'(dout_ch), 64'(17));
    rst_n = 1'b0;
    #1;
    rst_chk();
    q.delete();
    mcnt = '0;
    movr = 1'b0;
    exp_done = 1'b0;
    stall = 1'b0;
    frame_rdy = 1'b1;
    cyc();
    frame_rdy = 1'b0;
    cyc();
    chk("rst_hold_valid", 64'(dout_valid), 64'(0));
    rst_n = 1'b1;
    cyc();
    send_frame(32'h3000_0000);
    drain(1'b0, 32);

    // 6: drop and clear together, then counter wrap
    send_frame(32'h4000_0000);
    repeat (3) cyc();
    frame_rdy = 1'b1;
    clr_overrun = 1'b1;
    cyc();
    frame_rdy = 1'b0;
    clr_overrun = 1'b0;
    drain(1'b0, 0);
    clr_overrun = 1'b1;
    cyc();
    clr_overrun = 1'b0;
    force dut.frame_cnt = 16'hFFFF;
    mcnt = 16'hFFFF;
    cyc();
    release dut.frame_cnt;
    cyc();
    send_frame(32'h5000_0000);
    drain(1'b0, 32);
    chk("wrap_cnt", 64'(frame_cnt), 64'(0));

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
